// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared CPU defines: widths, reset PC, NOP, fetch FSM states
package inst_fetch_unit_pkg;

   localparam int ADDR_W = 32;
   localparam int INST_W = 32;

   localparam logic [ADDR_W-1:0] RESET_PC_DEF    = 32'h0000_0000;
   localparam logic [INST_W-1:0] INST_NOP        = 32'h0000_0000;
   localparam int                FETCH_BUF_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_unit_buf.sv
// rtl/inst_fetch_unit_buf.sv - two-entry in-order fetch buffer (fetch_buf)
module fetch_buf
   import inst_fetch_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [ADDR_W-1:0] push_pc_i,
   input  logic [INST_W-1:0] push_inst_i,
   input  logic              pop_i,
   input  logic              flush_i,
   output logic [1:0]        count_o,
   output logic [ADDR_W-1:0] head_pc_o,
   output logic [INST_W-1:0] head_inst_o
);

   fetch_entry_t ent0_q, ent0_d;
   fetch_entry_t ent1_q, ent1_d;
   fetch_entry_t in_ent;
   logic [1:0]   count_q, count_d;

   // ent0 is always the head; a pop shifts ent1 down
   always_comb begin
      ent0_d      = ent0_q;
      ent1_d      = ent1_q;
      count_d     = count_q;
      in_ent.pc   = push_pc_i;
      in_ent.inst = push_inst_i;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (count_q == 2'd0) begin
                  ent0_d  = in_ent;
                  count_d = 2'd1;
               end else if (count_q == 2'd1) begin
                  ent1_d  = in_ent;
                  count_d = 2'd2;
               end
            end
            2'b01: begin
               if (count_q != 2'd0) begin
                  ent0_d  = ent1_q;
                  count_d = count_q - 2'd1;
               end
            end
            2'b11: begin
               if (count_q == 2'd2) begin
                  ent0_d = ent1_q;
                  ent1_d = in_ent;
               end else begin
                  ent0_d  = in_ent;
                  count_d = 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ent0_q  <= '0;
         ent1_q  <= '0;
         count_q <= 2'd0;
      end else begin
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         count_q <= count_d;
      end
   end

   assign count_o     = count_q;
   assign head_pc_o   = ent0_q.pc;
   assign head_inst_o = ent0_q.inst;

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - credit-limited instruction fetch with bypass, branch and flush redirect
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int          BUF_DEPTH = FETCH_BUF_DEPTH
)(
   input  logic        clk,
   input  logic        rst,
   output logic        rom_ce_o,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_data_i,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   output logic        if_valid_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o
);

   localparam logic [2:0] CREDIT_LIM = 3'(BUF_DEPTH - 1);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         inflight_q, inflight_d;
   logic [31:0]  inflight_pc_q, inflight_pc_d;

   logic [1:0]   buf_count;
   logic [31:0]  head_pc, head_inst;
   logic         buf_empty, buf_push, buf_pop;
   logic         accept, take_branch, redirect, credit_ok, issue;
   logic [2:0]   occ, count_next, occ_next;

   fetch_buf u_buf (
      .clk         (clk),
      .rst         (rst),
      .push_i      (buf_push),
      .push_pc_i   (inflight_pc_q),
      .push_inst_i (rom_data_i),
      .pop_i       (buf_pop),
      .flush_i     (redirect),
      .count_o     (buf_count),
      .head_pc_o   (head_pc),
      .head_inst_o (head_inst)
   );

   // Buffered entries are older than the in-flight word, so they win the output
   always_comb begin
      buf_empty  = (buf_count == 2'd0);
      if_valid_o = !buf_empty || inflight_q;
      if (!buf_empty) begin
         if_pc_o   = head_pc;
         if_inst_o = head_inst;
      end else if (inflight_q) begin
         if_pc_o   = inflight_pc_q;
         if_inst_o = rom_data_i;
      end else begin
         if_pc_o   = '0;
         if_inst_o = INST_NOP;
      end
   end

   always_comb begin
      accept      = if_valid_o && !stall_i;
      take_branch = accept && branch_flag_i && !flush_i;
      redirect    = flush_i || take_branch;
      occ         = {1'b0, buf_count} + {2'b00, inflight_q};
      credit_ok   = (occ <= CREDIT_LIM + {2'b00, accept});
      buf_pop     = accept && !buf_empty;
      buf_push    = inflight_q && !(buf_empty && accept);

      state_d     = state_q;
      issue       = 1'b0;
      case (state_q)
         IDLE: state_d = RUN;
         RUN, HOLD: issue = credit_ok && !redirect;
         default: state_d = IDLE;
      endcase

      count_next = redirect ? 3'd0
                 : {1'b0, buf_count} + {2'b00, buf_push} - {2'b00, buf_pop};
      occ_next   = count_next + {2'b00, issue};
      if (state_q != IDLE)
         state_d = (occ_next > CREDIT_LIM) ? HOLD : RUN;
      if (redirect)
         state_d = RUN;

      pc_d = pc_q;
      if (flush_i)
         pc_d = align_word(new_pc_i);
      else if (take_branch)
         pc_d = align_word(branch_target_i);
      else if (issue)
         pc_d = pc_q + 32'd4;

      inflight_d    = issue;
      inflight_pc_d = issue ? pc_q : inflight_pc_q;
   end

   assign rom_ce_o   = issue;
   assign rom_addr_o = pc_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard bench for inst_fetch_unit against a program-order model
`timescale 1ns/1ps
module tb_inst_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        rom_ce_o;
   logic [31:0] rom_addr_o;
   logic [31:0] rom_data_i;
   logic        stall_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic        flush_i;
   logic [31:0] new_pc_i;
   logic        if_valid_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;

   int checks  = 0;
   int errors  = 0;
   int n_deliv = 0;

   inst_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .rom_ce_o        (rom_ce_o),
      .rom_addr_o      (rom_addr_o),
      .rom_data_i      (rom_data_i),
      .stall_i         (stall_i),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .flush_i         (flush_i),
      .new_pc_i        (new_pc_i),
      .if_valid_o      (if_valid_o),
      .if_pc_o         (if_pc_o),
      .if_inst_o       (if_inst_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM holds word i at byte address 4i; unrequested cycles return noise
   always @(posedge clk) rom_data_i <= rom_ce_o ? (rom_addr_o >> 2) : $urandom;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected program order: sequential words from the last restart point
   logic [31:0] exp_q[$];
   logic [31:0] gen_pc;
   logic [31:0] exp_pc;

   function automatic void restart(input logic [31:0] addr);
      exp_q.delete();
      gen_pc = addr & ~32'h3;
   endfunction

   function automatic void refill();
      while (exp_q.size() < 4) begin
         exp_q.push_back(gen_pc);
         gen_pc = gen_pc + 32'd4;
      end
   endfunction

   logic        rst_at_edge = 1'b0;
   int          since_rst = 0;
   logic        disturbed = 1'b0;
   logic        prev_redirect = 1'b0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_pc = '0;
   logic [31:0] prev_inst = '0;

   always @(posedge clk) rst_at_edge <= rst;

   always @(negedge clk) begin
      if (!rst_at_edge) begin
         chk("rst_rom_ce", {31'b0, rom_ce_o}, 32'd0);
         chk("rst_rom_addr", rom_addr_o, RST_PC);
         chk("rst_if_valid", {31'b0, if_valid_o}, 32'd0);
         chk("rst_if_pc", if_pc_o, 32'd0);
         chk("rst_if_inst", if_inst_o, 32'd0);
         restart(RST_PC);
         since_rst     = 0;
         disturbed     = 1'b0;
         prev_redirect = 1'b0;
         prev_hold     = 1'b0;
      end else begin
         since_rst++;
         if (flush_i) disturbed = 1'b1;
         if (since_rst == 1 && !disturbed) begin
            chk("first_req_ce", {31'b0, rom_ce_o}, 32'd1);
            chk("first_req_addr", rom_addr_o, RST_PC);
            chk("first_valid_early", {31'b0, if_valid_o}, 32'd0);
         end
         if (since_rst == 2 && !disturbed)
            chk("first_valid_cycle2", {31'b0, if_valid_o}, 32'd1);
         if (prev_redirect)
            chk("bubble_after_redirect", {31'b0, if_valid_o}, 32'd0);
         if (prev_hold) begin
            chk("stall_hold_valid", {31'b0, if_valid_o}, 32'd1);
            chk("stall_hold_pc", if_pc_o, prev_pc);
            chk("stall_hold_inst", if_inst_o, prev_inst);
         end
         if (flush_i) begin
            restart(new_pc_i);
         end else if (if_valid_o && !stall_i) begin
            refill();
            exp_pc = exp_q.pop_front();
            chk("deliver_pc", if_pc_o, exp_pc);
            chk("deliver_inst", if_inst_o, exp_pc >> 2);
            n_deliv++;
            if (branch_flag_i) restart(branch_target_i);
         end
         prev_redirect = flush_i || (if_valid_o && !stall_i && branch_flag_i);
         prev_hold     = if_valid_o && stall_i && !flush_i;
         prev_pc       = if_pc_o;
         prev_inst     = if_inst_o;
      end
   end

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 2))
         0:       return 32'($urandom_range(0, 255));
         1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int stall_left;
      rst = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0;
      flush_i = 1'b0; new_pc_i = '0;
      repeat (2) next_cycle();
      rst = 1'b1;

      // Stream from reset, stall 3 cycles with 0x0C presented
      stall_left = 3;
      for (int i = 0; i < 14; i++) begin
         next_cycle();
         stall_i = if_valid_o && (if_pc_o == 32'h0000_000C) && (stall_left > 0);
         if (stall_i) stall_left--;
      end
      stall_i = 1'b0;

      // One-cycle reset mid-stream, then taken branch in 0x0C's accept cycle
      next_cycle();
      rst = 1'b0;
      next_cycle();
      rst = 1'b1;
      for (int i = 0; i < 14; i++) begin
         next_cycle();
         branch_flag_i   = if_valid_o && (if_pc_o == 32'h0000_000C);
         branch_target_i = 32'h0000_0020;
      end
      branch_flag_i = 1'b0;

      // Flush while stalled with the buffer full
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         stall_i  = 1'b1;
         flush_i  = (i == 3);
         new_pc_i = 32'h0000_0180;
      end
      next_cycle();
      stall_i = 1'b0; flush_i = 1'b0;
      repeat (6) next_cycle();

      // Wrap-around start, then an unaligned restart address
      flush_i = 1'b1; new_pc_i = 32'hFFFF_FFF8;
      next_cycle();
      flush_i = 1'b0;
      repeat (8) next_cycle();
      flush_i = 1'b1; new_pc_i = 32'h0000_0203;
      next_cycle();
      flush_i = 1'b0;
      repeat (6) next_cycle();

      for (int i = 0; i < 3000; i++) begin
         next_cycle();
         rst             = ($urandom_range(0, 399) != 0);
         stall_i         = ($urandom_range(0, 9) < 3);
         branch_flag_i   = ($urandom_range(0, 5) == 0);
         branch_target_i = rand_addr();
         flush_i         = ($urandom_range(0, 39) == 0);
         new_pc_i        = rand_addr();
      end
      rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; flush_i = 1'b0;
      repeat (3) next_cycle();
      @(negedge clk);
      #1;
      chk("deliveries_min", {31'b0, (n_deliv >= 500)}, 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
